rf_port_arbiter: RTL
====================

// Module: rf_port_arbiter
// PURPOSE
//  Shares the MCU 8x8 register file between two requesters: requester 0 is the execute unit, requester 1 is the debug/loader port.
//  Each transaction is a valid/ready handshake carrying two read addresses, an optional write and its data.
//  The block sequences the register file through an IDLE -> ISSUE -> RESP state machine.
//  It returns the read data to the granted requester with a one-cycle rsp pulse.
//  Sits between the requesters and the register file's clk/A_add/B_add/D_add/data_in/write_enable ports.
// PARAMETERS
//  DATA_W      8  width of register data
//  ADDR_W      3  width of register addresses (2**ADDR_W registers)
//  FIXED_PRIO  0  0 = round-robin between requesters; 1 = requester 0 always wins a tie
// PORTS
//  clk            in   1       single clock; all state updates on posedge
//  rst            in   1       asynchronous, active-high reset
//  rN_valid       in   1       requester N (N=0,1) has a transaction; held until rN_ready
//  rN_ready       out  1       handshake accept for requester N (combinational)
//  rN_we          in   1       transaction includes a write of rN_wdata to rN_d_add
//  rN_a_add       in   ADDR_W  read address A
//  rN_b_add       in   ADDR_W  read address B
//  rN_d_add       in   ADDR_W  write address
//  rN_wdata       in   DATA_W  write data
//  rN_rsp_valid   out  1       one-cycle pulse: rsp_data_a/b hold requester N's result
//  rsp_data_a     out  DATA_W  read data A (shared; qualified by rN_rsp_valid)
//  rsp_data_b     out  DATA_W  read data B
//  busy           out  1       high whenever state != IDLE
//  rf_a_add       out  ADDR_W  to register file A_add
//  rf_b_add       out  ADDR_W  to register file B_add
//  rf_d_add       out  ADDR_W  to register file D_add
//  rf_data_in     out  DATA_W  to register file data_in
//  rf_write_en    out  1       to register file write_enable
//  rf_data_a      in   DATA_W  from register file data_a (registered, 1-cycle read latency)
//  rf_data_b      in   DATA_W  from register file data_b
// BEHAVIOUR
//  - Register file contract:
//    - write and read both occur on posedge.
//    - Read data appears one cycle after the address is presented.
//    - A read of the address being written on the same edge returns the OLD value.
//  - Reset (async, immediate), with all outputs 0 while rst is high:
//    - state=IDLE, prio=0.
//    - rf_* address/data registers = 0, rf_write_en=0.
//    - rN_rsp_valid=0, rN_ready=0, busy=0.
//  - IDLE:
//    - r0_ready = r0_valid & (!r1_valid | prio==0).
//    - r1_ready = r1_valid & (!r0_valid | prio==1).
//    - At most one ready is high in any cycle. ready is 0 in ISSUE/RESP.
//    - On a handshake edge: latch the winner's a/b/d/wdata/we into rf_* registers, record owner, go to ISSUE.
//    - Round-robin: prio <= ~owner. With FIXED_PRIO=1, prio stays 0.
//  - ISSUE (1 cycle):
//    - rf_* outputs stable.
//    - rf_write_en = latched we; the write commits at the end of this cycle.
//    - Go to RESP.
//  - RESP (1 cycle):
//    - r<owner>_rsp_valid=1 (registered decode of state).
//    - rsp_data_a/b = rf_data_a/b, pass-through.
//    - rf_write_en=0.
//    - Return to IDLE.
//  - Latency: handshake edge -> rsp_valid high 2 cycles later. Throughput: 1 transaction per 3 cycles.
//  - A transaction that reads the register it writes gets the pre-write value. A following transaction sees the new value.
//  - rsp_data_a/b are undefined outside RESP; benches compare only when rN_rsp_valid is high.
//  - Inputs are ignored outside the handshake cycle. A requester that drops valid before ready loses nothing: no state change.
//  - Reset mid-ISSUE:
//    - rf_write_en falls immediately.
//    - A write is suppressed unless its edge already occurred.
//    - No rsp pulse is produced.
//  - rf_a_add/rf_b_add/rf_d_add/rf_data_in hold their last latched values in IDLE. rf_write_en is 0 in IDLE.
// TESTING
//  1. Reset: assert rst mid-cycle -> all outputs 0 asynchronously; after release, busy=0 and both ready follow valid.
//  2. Single write+read: r0 we=1 d=3 wdata=8'hA5 a=3 b=0 -> r0_rsp_valid 2 cycles later, data_a = old R3; next r0 read a=3 -> data_a=8'hA5.
//  3. Contention, round-robin: both valid every cycle for 6 transactions -> grants alternate 0,1,0,1,0,1; each owner gets exactly one rsp pulse per grant.
//  4. FIXED_PRIO=1: both valid continuously -> r1 never granted while r0_valid high; r1 granted on the first IDLE cycle with r0_valid=0.
//  5. Write all 8 regs from r1 (wdata=8'h10+i), then read pairs (i,7-i) from r0 -> data_a=8'h10+i, data_b=8'h17-i.
//  6. Reset during ISSUE of a write of 8'hFF to R5 -> rf_write_en low immediately, no rsp pulse, R5 read later shows its prior value.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter that sequences a registered-read register file.
// Each granted transaction runs IDLE -> ISSUE -> RESP and ends with a one-cycle rsp pulse.
module rf_port_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_a_add,
  input  logic [ADDR_W-1:0] r0_b_add,
  input  logic [ADDR_W-1:0] r0_d_add,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_a_add,
  input  logic [ADDR_W-1:0] r1_b_add,
  input  logic [ADDR_W-1:0] r1_d_add,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_a_add,
  output logic [ADDR_W-1:0] rf_b_add,
  output logic [ADDR_W-1:0] rf_d_add,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_write_en,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;
  logic   prio_q;
  logic   owner_q;
  logic   grant0, grant1;

  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant0 = r0_valid & (~r1_valid | ~prio_q);
        grant1 = r1_valid & (~r0_valid | prio_q);
        if (grant0 | grant1) begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is forced low while reset is held even though the state already reads idle.
  assign r0_ready = grant0 & ~rst;
  assign r1_ready = grant1 & ~rst;
  assign busy     = (state_q != StIdle);

  // Read data is passed straight through, but only while a response is being presented.
  assign rsp_data_a = (r0_rsp_valid | r1_rsp_valid) ? rf_data_a : '0;
  assign rsp_data_b = (r0_rsp_valid | r1_rsp_valid) ? rf_data_b : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      rf_a_add     <= '0;
      rf_b_add     <= '0;
      rf_d_add     <= '0;
      rf_data_in   <= '0;
      rf_write_en  <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 | grant1) begin
        owner_q     <= grant1;
        rf_a_add    <= grant1 ? r1_a_add : r0_a_add;
        rf_b_add    <= grant1 ? r1_b_add : r0_b_add;
        rf_d_add    <= grant1 ? r1_d_add : r0_d_add;
        rf_data_in  <= grant1 ? r1_wdata : r0_wdata;
        rf_write_en <= grant1 ? r1_we    : r0_we;
        if (FIXED_PRIO) begin
          prio_q <= 1'b0;
        end else begin
          prio_q <= grant0;
        end
      end
      // The write commits on the edge that leaves ISSUE; the read issued on that edge
      // returns the pre-write value during RESP.
      if (state_q == StIssue) begin
        rf_write_en  <= 1'b0;
        r0_rsp_valid <= ~owner_q;
        r1_rsp_valid <= owner_q;
      end else begin
        r0_rsp_valid <= 1'b0;
        r1_rsp_valid <= 1'b0;
      end
    end
  end

endmodule
